quick_spi_slave: RTL and testbench
==================================

# quick_spi_slave

SPI responder for the QuickSPI family, i.e. the other end of the wire from the `quick_spi` initiator. It runs on the system clock, oversamples the external `sclk`/`ss_n`/`mosi` pins, and shifts received bits into words. It returns transmit words on `miso` in any of the four CPOL/CPHA modes. Words are exchanged with local logic through a ready/valid transmit port and a pulsed receive port.

## Interface
- `WORD_WIDTH`, default 8: bits per word; legal range 2..16.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cpol` input 1: clock idle level; latched at frame start.
- `cpha` input 1: clock phase; latched at frame start.
- `sclk` input 1: SPI clock from the initiator; asynchronous.
- `ss_n` input 1: slave select, active low; asynchronous.
- `mosi` input 1: serial data in; asynchronous.
- `miso` output 1: serial data out.
- `miso_oe` output 1: `miso` output enable for the pad tristate.
- `tx_data` input WORD_WIDTH: next word to send.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: the holding buffer is empty.
- `rx_data` output WORD_WIDTH: last complete received word.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `underrun` output 1: one-cycle pulse when a word is loaded while the holding buffer is empty.
- `busy` output 1: a frame is active.
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `underrun`=0, `busy`=0.

## Operation
- **Input synchronisation:** `sclk`, `ss_n` and `mosi` each pass through a 2-flop synchroniser. Edges are detected against a third registered copy.
- **Edge roles:**
  - The leading edge is the `sclk` transition away from the latched `cpol`; the trailing edge is the return to it.
  - `cpha`=0: sample on the leading edge, drive on the trailing edge.
  - `cpha`=1: drive on the leading edge, sample on the trailing edge.
- **State machine (2 states):**
  - **S_IDLE:** when a falling `ss_n` is detected, latch `cpol`/`cpha`, clear the bit counter, perform a word load, set `busy`, go to S_SHIFT.
  - **S_SHIFT:**
    - Each sample edge shifts `mosi` into the receive shift register and increments the bit counter.
    - When the counter reaches WORD_WIDTH-1 on a sample edge: update `rx_data`, pulse `rx_valid`, clear the counter and perform a word load.
    - With `cpha`=1, the first drive edge of each word outputs bit 0. With `cpha`=0, the word load itself places bit 0 on `miso`.
    - A detected rising `ss_n` returns to S_IDLE.
- **Word load:**
  - If the holding buffer is full, copy it into the transmit shift register and empty the buffer.
  - Otherwise load all zeros and pulse `underrun`.
  - The load uses the buffer contents as they were before the cycle. A `tx_valid` accepted in the same cycle fills the buffer for the next word.
- **TX handshake:**
  - Transfer happens when `tx_valid && tx_ready`; `tx_ready` = buffer empty.
  - The buffer may be filled in S_IDLE ahead of the frame.
- **Bit order:** LSB first (bit 0 first) by default; see Configuration.
- **Frame abort (`ss_n` rises mid-word):**
  - The partial received word is discarded; no `rx_valid`.
  - The partial transmit word is discarded.
  - The holding buffer keeps its content.
  - `miso_oe` and `busy` drop.
- **Pin control:** `miso_oe` is high only in S_SHIFT. `miso` holds its last value when not enabled.
- **Reset during a frame:** all state and outputs return to reset values immediately. The responder waits for a fresh falling `ss_n`; a select that is already low at reset release is ignored until it goes high and falls again.

## Timing
- Pin-to-detect latency is 3 `clk` cycles (2 synchroniser + 1 edge register).
- The `sclk` high and low times must each be at least 4 `clk` periods. `ss_n` setup to the first `sclk` edge must also be at least 4 `clk` periods.
- `miso` and `miso_oe` change in the cycle after the detected drive event (`ss_n` fall or drive edge).
- `rx_valid` is asserted in the cycle after the final sample edge is detected, together with the new `rx_data`.
- `underrun` pulses in the same cycle as `rx_valid` for in-frame word loads. For the first word of a frame, it pulses the cycle after the `ss_n` fall is detected.
- `tx_ready` drops the cycle after acceptance and rises the cycle after a word load.

## Configuration
- **`QUICK_SPI_SLAVE_MSB_FIRST_EN` defined:** words are transmitted and received MSB first; `rx_data[WORD_WIDTH-1]` is the first bit received.
- **Not defined:** LSB first, matching the QuickSPI initiator's bit order.

## Structure
- **Shared package `quick_spi_pkg`:**
  - State encodings S_IDLE and S_SHIFT.
  - Synchroniser depth constant (2).
  - Minimum oversampling constant (4).
- **Sub-module `quick_spi_sync_edge`:** 2-flop synchroniser plus rise/fall detector. Instantiated three times: `sclk`, `ss_n`, `mosi` (`mosi` uses the synchronised level only).

## Test plan
1. **Mode 0 single word:** `cpol`=0, `cpha`=0, `tx_data`=8'hA5 preloaded; initiator sends 8'h3C LSB first → one `rx_valid` with `rx_data`=8'h3C; initiator samples 1,0,1,0,0,1,0,1 on `miso`.
2. **All four modes:** `tx`=8'h69, `mosi` word 8'h96 → `rx_data`=8'h96 and initiator receives 8'h69 in every mode; no `underrun`.
3. **Burst:** 8'h11 then 8'h22 supplied via handshake during one `ss_n`-low frame → two `rx_valid` pulses; `miso` words 8'h11, 8'h22; `tx_ready` rises after each load.
4. **Underrun:** no `tx_valid` before frame → `miso` all zeros, one `underrun` pulse, `rx_data` still correct.
5. **Abort:** `ss_n` raised after 5 bits → no `rx_valid`, `miso_oe` low within 4 cycles. The next frame receives 8'hC3 correctly aligned.
6. **Reset mid-frame:** `reset_n` pulsed low at bit 3 → all outputs at reset values; a full frame after re-select completes correctly.

Source files
------------

// File: rtl/quick_spi_pkg.sv
// quick_spi_pkg: shared state encodings and timing constants for the QuickSPI family.
package quick_spi_pkg;
    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
    localparam int SYNC_DEPTH     = 2;
    localparam int MIN_OVERSAMPLE = 4;
endpackage

// File: rtl/quick_spi_sync_edge.sv
// quick_spi_sync_edge: 2-flop synchroniser with rise/fall detection against a third registered copy.
module quick_spi_sync_edge
    import quick_spi_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  r_prev;
    // Reset to low so a select already low at reset release never looks like a fresh fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_pin};
            r_prev <= r_sync[SYNC_DEPTH-1];
        end
    end
    assign o_level = r_sync[SYNC_DEPTH-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/quick_spi_slave.sv
// quick_spi_slave: oversampling SPI responder, all four CPOL/CPHA modes, ready/valid TX and pulsed RX.
// Define QUICK_SPI_SLAVE_MSB_FIRST_EN for MSB-first words; LSB first otherwise.
module quick_spi_slave
    import quick_spi_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  underrun,
    output logic                  busy
);
    localparam int            CW   = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

    state_t                r_state, w_next;
    logic                  r_cpol, r_cpha, r_buf_full, r_miso, r_rx_valid, r_underrun;
    logic [CW-1:0]         r_cnt;
    logic [WORD_WIDTH-1:0] r_rx_sh, r_tx_sh, r_buf, r_rx_data;
    logic                  w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi;
    logic                  w_unused_sclk_level, w_unused_ss_level, w_unused_mosi_rise, w_unused_mosi_fall;
    logic                  w_lead, w_trail, w_start, w_sample, w_drive, w_last, w_load, w_ld_cpha;
    logic [WORD_WIDTH-1:0] w_ld_word, w_rx_next;

    quick_spi_sync_edge u_sclk (.clk(clk), .reset_n(reset_n), .i_pin(sclk), .o_level(w_unused_sclk_level),
                                .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    quick_spi_sync_edge u_ss   (.clk(clk), .reset_n(reset_n), .i_pin(ss_n), .o_level(w_unused_ss_level),
                                .o_rise(w_ss_rise), .o_fall(w_ss_fall));
    quick_spi_sync_edge u_mosi (.clk(clk), .reset_n(reset_n), .i_pin(mosi), .o_level(w_mosi),
                                .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall));

`ifdef QUICK_SPI_SLAVE_MSB_FIRST_EN
    function automatic logic tx_head(input logic [WORD_WIDTH-1:0] v);
        return v[WORD_WIDTH-1];
    endfunction
    function automatic logic [WORD_WIDTH-1:0] tx_shift(input logic [WORD_WIDTH-1:0] v);
        return {v[WORD_WIDTH-2:0], 1'b0};
    endfunction
    assign w_rx_next = {r_rx_sh[WORD_WIDTH-2:0], w_mosi};
`else
    function automatic logic tx_head(input logic [WORD_WIDTH-1:0] v);
        return v[0];
    endfunction
    function automatic logic [WORD_WIDTH-1:0] tx_shift(input logic [WORD_WIDTH-1:0] v);
        return {1'b0, v[WORD_WIDTH-1:1]};
    endfunction
    assign w_rx_next = {w_mosi, r_rx_sh[WORD_WIDTH-1:1]};
`endif

    assign w_lead  = r_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail = r_cpol ? w_sclk_rise : w_sclk_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // With cpha=0 the word load already drove bit 0, so the trailing edge that closes a word is skipped.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_sample = 1'b0;
        w_drive  = 1'b0;
        if (r_state == S_IDLE) begin
            w_start = w_ss_fall;
            w_next  = w_ss_fall ? S_SHIFT : S_IDLE;
        end else begin
            w_next   = w_ss_rise ? S_IDLE : S_SHIFT;
            w_sample = !w_ss_rise && (r_cpha ? w_trail : w_lead);
            w_drive  = !w_ss_rise && (r_cpha ? w_lead : (w_trail && r_cnt != '0));
        end
    end

    assign w_last    = w_sample && (r_cnt == LAST);
    assign w_load    = w_start || w_last;
    assign w_ld_cpha = w_start ? cpha : r_cpha;
    assign w_ld_word = r_buf_full ? r_buf : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_cnt      <= '0;
            r_rx_sh    <= '0;
            r_tx_sh    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_rx_valid <= w_last;
            r_underrun <= w_load && !r_buf_full;
            if (w_start) begin
                r_cpol <= cpol;
                r_cpha <= cpha;
                r_cnt  <= '0;
            end
            if (w_sample) begin
                r_rx_sh <= w_rx_next;
                r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_last) r_rx_data <= w_rx_next;
            // cpha=0 puts bit 0 out at load time and keeps only the remaining bits in the shifter.
            if (w_load) begin
                r_tx_sh <= w_ld_cpha ? w_ld_word : tx_shift(w_ld_word);
                if (!w_ld_cpha) r_miso <= tx_head(w_ld_word);
            end else if (w_drive) begin
                r_miso  <= tx_head(r_tx_sh);
                r_tx_sh <= tx_shift(r_tx_sh);
            end
            if (w_load && r_buf_full) begin
                r_buf_full <= 1'b0;
            end else if (tx_valid && !r_buf_full) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end
        end
    end

    assign miso     = r_miso;
    assign miso_oe  = (r_state == S_SHIFT);
    assign busy     = (r_state == S_SHIFT);
    assign tx_ready = !r_buf_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign underrun = r_underrun;
endmodule

// File: tb/tb_quick_spi_slave.sv
// tb_quick_spi_slave: directed SPI-initiator stimulus with immediate-assertion checks.
module tb_quick_spi_slave;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset_n, cpol, cpha, sclk, ss_n, mosi;
    logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, underrun, busy;
    logic [7:0] tx_data, rx_data, s;
    int         vectors = 0, miscompares = 0, rx_cnt = 0, ur_cnt = 0, rx0, ur0;

    quick_spi_slave #(.WORD_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (underrun) ur_cnt <= ur_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic frame_start();
        ss_n = 1'b0;
        wait_neg(H);
    endtask

    task automatic frame_end();
        wait_neg(H);
        ss_n = 1'b1;
        wait_neg(2 * H);
    endtask

    task automatic xfer(input logic [7:0] m, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                mosi = m[i];
                wait_neg(H);
                sclk = ~cpol;
                r[i] = miso;
                wait_neg(H);
                sclk = cpol;
            end else begin
                wait_neg(H);
                sclk = ~cpol;
                mosi = m[i];
                wait_neg(H);
                sclk = cpol;
                r[i] = miso;
            end
        end
    endtask

    task automatic check_reset_values(input string ph);
        check({ph, "_miso"}, 16'(miso), 16'd0);
        check({ph, "_miso_oe"}, 16'(miso_oe), 16'd0);
        check({ph, "_tx_ready"}, 16'(tx_ready), 16'd1);
        check({ph, "_rx_data"}, 16'(rx_data), 16'd0);
        check({ph, "_rx_valid"}, 16'(rx_valid), 16'd0);
        check({ph, "_underrun"}, 16'(underrun), 16'd0);
        check({ph, "_busy"}, 16'(busy), 16'd0);
    endtask

    initial begin
        reset_n = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        wait_neg(3);
        check_reset_values("rst");
        reset_n = 1'b1;
        wait_neg(4);

        // Mode 0 single word
        check("t1_tx_ready_idle", 16'(tx_ready), 16'd1);
        push(8'hA5);
        check("t1_tx_ready_full", 16'(tx_ready), 16'd0);
        rx0 = rx_cnt;
        frame_start();
        check("t1_busy", 16'(busy), 16'd1);
        check("t1_miso_oe", 16'(miso_oe), 16'd1);
        check("t1_tx_ready_loaded", 16'(tx_ready), 16'd1);
        xfer(8'h3C, 8, s);
        frame_end();
        check("t1_rx_data", 16'(rx_data), 16'h3C);
        check("t1_rx_pulses", 16'(rx_cnt - rx0), 16'd1);
        check("t1_miso_word", 16'(s), 16'hA5);
        check("t1_busy_end", 16'(busy), 16'd0);
        check("t1_miso_oe_end", 16'(miso_oe), 16'd0);

        // All four modes
        for (int md = 0; md < 4; md++) begin
            cpol = md[1];
            cpha = md[0];
            sclk = cpol;
            wait_neg(2 * H);
            push(8'h69);
            rx0 = rx_cnt;
            ur0 = ur_cnt;
            frame_start();
            push(8'h69);
            xfer(8'h96, 8, s);
            frame_end();
            check($sformatf("t2_m%0d_rx_data", md), 16'(rx_data), 16'h96);
            check($sformatf("t2_m%0d_miso_word", md), 16'(s), 16'h69);
            check($sformatf("t2_m%0d_rx_pulses", md), 16'(rx_cnt - rx0), 16'd1);
            check($sformatf("t2_m%0d_underrun", md), 16'(ur_cnt - ur0), 16'd0);
        end

        // Burst of two words in one frame
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
        wait_neg(2 * H);
        push(8'h11);
        rx0 = rx_cnt;
        frame_start();
        check("t3_tx_ready_load1", 16'(tx_ready), 16'd1);
        push(8'h22);
        check("t3_tx_ready_full", 16'(tx_ready), 16'd0);
        xfer(8'hA1, 8, s);
        check("t3_miso_word1", 16'(s), 16'h11);
        check("t3_rx_data1", 16'(rx_data), 16'hA1);
        check("t3_tx_ready_load2", 16'(tx_ready), 16'd1);
        xfer(8'hB2, 8, s);
        frame_end();
        check("t3_miso_word2", 16'(s), 16'h22);
        check("t3_rx_data2", 16'(rx_data), 16'hB2);
        check("t3_rx_pulses", 16'(rx_cnt - rx0), 16'd2);

        // Underrun on the first word of a frame
        ur0 = ur_cnt;
        frame_start();
        check("t4_underrun_start", 16'(ur_cnt - ur0), 16'd1);
        push(8'hFF);
        xfer(8'h5A, 8, s);
        frame_end();
        check("t4_miso_word", 16'(s), 16'h00);
        check("t4_underrun_total", 16'(ur_cnt - ur0), 16'd1);
        check("t4_rx_data", 16'(rx_data), 16'h5A);

        // Abort after 5 bits, buffer retained, next frame aligned
        push(8'hE7);
        rx0 = rx_cnt;
        frame_start();
        push(8'h5A);
        xfer(8'hFF, 5, s);
        ss_n = 1'b1;
        wait_neg(4);
        check("t5_miso_oe_abort", 16'(miso_oe), 16'd0);
        check("t5_busy_abort", 16'(busy), 16'd0);
        wait_neg(2 * H);
        check("t5_rx_pulses_abort", 16'(rx_cnt - rx0), 16'd0);
        check("t5_buffer_kept", 16'(tx_ready), 16'd0);
        frame_start();
        xfer(8'hC3, 8, s);
        frame_end();
        check("t5_rx_data", 16'(rx_data), 16'hC3);
        check("t5_miso_word", 16'(s), 16'h5A);
        check("t5_rx_pulses", 16'(rx_cnt - rx0), 16'd1);

        // Reset during a frame
        push(8'h99);
        frame_start();
        push(8'h44);
        xfer(8'hFF, 3, s);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("t6");
        reset_n = 1'b1;
        wait_neg(2 * H);
        check("t6_low_select_ignored", 16'(busy), 16'd0);
        ss_n = 1'b1;
        wait_neg(2 * H);
        push(8'h77);
        frame_start();
        xfer(8'h5E, 8, s);
        frame_end();
        check("t6_rx_data", 16'(rx_data), 16'h5E);
        check("t6_miso_word", 16'(s), 16'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
